pll_lock_ctrl: RTL



---
 rtl/pll_lock_ctrl_if.sv | 40 ++++
 rtl/pll_lock_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl_if.sv
// -----------------------------------------------------------------------------
// pll_lock_ctrl_if
// Groups the PLL supervisor's control/status signals into one bundle.
//
// Signals:
//   soft_rst      supervisor input   one-cycle synchronous relock request
//   pll_lock      supervisor input   raw PLL LOCK (asynchronous)
//   pll_rst       supervisor output  PLL reset, active-high
//   pll_pwd       supervisor output  PLL power-down
//   sys_rst_n     supervisor output  downstream reset, active-low
//   pll_ready     supervisor output  high while lock is qualified (RUN)
//   pll_fail      supervisor output  sticky failure after retries exhausted
//   retry_cnt     supervisor output  retries used in the current sequence
//   lost_lock_cnt supervisor output  saturating count of RUN lock losses
//
// Modports:
//   master  the side that requests relock and watches status (system / bench)
//   slave   the supervisor itself (pll_lock_ctrl)
// -----------------------------------------------------------------------------
interface pll_lock_ctrl_if;
    logic       soft_rst;
    logic       pll_lock;
    logic       pll_rst;
    logic       pll_pwd;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       pll_fail;
    logic [3:0] retry_cnt;
    logic [7:0] lost_lock_cnt;

    modport master (
        output soft_rst, pll_lock,
        input  pll_rst, pll_pwd, sys_rst_n, pll_ready, pll_fail, retry_cnt, lost_lock_cnt
    );

    modport slave (
        input  soft_rst, pll_lock,
        output pll_rst, pll_pwd, sys_rst_n, pll_ready, pll_fail, retry_cnt, lost_lock_cnt
    );
endinterface

// File: rtl/pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// pll_lock_ctrl
// Lock supervisor and reset sequencer for the HDMI-domain PLL. Holds the PLL in
// reset, qualifies the asynchronous LOCK through a 2-flop synchronizer and a
// stability window, then releases the downstream reset. Lock loss in RUN or a
// qualification timeout triggers a bounded number of retries; when they are
// exhausted the block parks in a sticky FAIL state until soft_rst or rst_n.
//
// Ports:
//   clkin1   PLL reference clock, the only clock of this block
//   rst_n    asynchronous active-low reset
//   pll_if   pll_lock_ctrl_if.slave bundle (soft_rst, pll_lock in; pll_rst,
//            pll_pwd, sys_rst_n, pll_ready, pll_fail, retry_cnt,
//            lost_lock_cnt out)
//
// Optional feature macro: PLL_PWD_ON_FAIL_EN
//   defined   -> pll_pwd is high while in FAIL
//   undefined -> pll_pwd is tied low
//
// Timing notes: the FSM sees pll_lock three edges after it is applied (two
// synchronizer flops plus the FSM register). The timeout window covers
// LOCK_TIMEOUT_CYC cycles spent in WAIT_LOCK/STABLE. All outputs are registered
// and decoded from the next state, so they switch on the transition edge.
// -----------------------------------------------------------------------------
module pll_lock_ctrl #(
    parameter int RST_HOLD_CYC     = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65535,
    parameter int MAX_RETRY        = 7,
    parameter int LOSS_FILTER      = 4
) (
    input  logic         clkin1,
    input  logic         rst_n,
    pll_lock_ctrl_if.slave pll_if
);

    localparam int HOLD_W = (RST_HOLD_CYC > 1)     ? $clog2(RST_HOLD_CYC)     : 1;
    localparam int STAB_W = (LOCK_STABLE_CYC > 1)  ? $clog2(LOCK_STABLE_CYC)  : 1;
    localparam int TMO_W  = (LOCK_TIMEOUT_CYC > 1) ? $clog2(LOCK_TIMEOUT_CYC) : 1;
    localparam int LOSS_W = (LOSS_FILTER > 1)      ? $clog2(LOSS_FILTER)      : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);
    localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [STAB_W-1:0]   stable_q, stable_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic [3:0]          retry_q, retry_d;
    logic [7:0]          lost_q, lost_d;

    logic sync1_q, lock_s_q;
    logic qualify;
    logic pll_rst_q, pll_rst_d;
    logic ready_q, ready_d;
    logic fail_q, fail_d;

    // 2-flop synchronizer for the asynchronous LOCK input
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_if.pll_lock;
            lock_s_q <= sync1_q;
        end
    end

    // This lock_s sample completes the stability window. From WAIT_LOCK it can
    // only complete the window when a single cycle is enough.
    assign qualify = lock_s_q &&
                     ((state_q == S_STABLE) ? (stable_q == STAB_LAST) : (LOCK_STABLE_CYC == 1));

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        stable_d = stable_q;
        tmo_d    = tmo_q;
        loss_d   = loss_q;
        retry_d  = retry_q;
        lost_d   = lost_q;

        if (pll_if.soft_rst) begin
            // Relock request overrides everything, including a coincident loss
            state_d  = S_RESET;
            hold_d   = '0;
            stable_d = '0;
            tmo_d    = '0;
            loss_d   = '0;
            retry_d  = '0;
        end else begin
            unique case (state_q)
                S_RESET: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d  = S_WAIT_LOCK;
                        hold_d   = '0;
                        tmo_d    = '0;
                        stable_d = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_WAIT_LOCK, S_STABLE: begin
                    if (qualify) begin
                        // Qualification beats a coincident timeout
                        state_d  = S_RUN;
                        stable_d = '0;
                        tmo_d    = '0;
                        loss_d   = '0;
                        retry_d  = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        stable_d = '0;
                        tmo_d    = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_RESET;
                            hold_d  = '0;
                        end
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                        if (lock_s_q) begin
                            state_d  = S_STABLE;
                            stable_d = (state_q == S_STABLE) ? stable_q + 1'b1 : STAB_W'(1);
                        end else begin
                            // A bounce restarts the window but not the timeout
                            state_d  = S_WAIT_LOCK;
                            stable_d = '0;
                        end
                    end
                end
                S_RUN: begin
                    if (!lock_s_q) begin
                        if (loss_q == LOSS_LAST) begin
                            state_d = S_RESET;
                            hold_d  = '0;
                            loss_d  = '0;
                            if (lost_q != 8'hFF) begin
                                lost_d = lost_q + 1'b1;
                            end
                        end else begin
                            loss_d = loss_q + 1'b1;
                        end
                    end else begin
                        loss_d = '0;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_RESET;
                    hold_d  = '0;
                end
            endcase
        end

        // Outputs decoded from the next state so they move with the transition
        pll_rst_d = (state_d == S_RESET) || (state_d == S_FAIL);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            hold_q    <= '0;
            stable_q  <= '0;
            tmo_q     <= '0;
            loss_q    <= '0;
            retry_q   <= '0;
            lost_q    <= '0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stable_q  <= stable_d;
            tmo_q     <= tmo_d;
            loss_q    <= loss_d;
            retry_q   <= retry_d;
            lost_q    <= lost_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

`ifdef PLL_PWD_ON_FAIL_EN
    logic pwd_q;
    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            pwd_q <= 1'b0;
        end else begin
            pwd_q <= (state_d == S_FAIL);
        end
    end
    assign pll_if.pll_pwd = pwd_q;
`else
    assign pll_if.pll_pwd = 1'b0;
`endif

    assign pll_if.pll_rst       = pll_rst_q;
    assign pll_if.sys_rst_n     = ready_q;
    assign pll_if.pll_ready     = ready_q;
    assign pll_if.pll_fail      = fail_q;
    assign pll_if.retry_cnt     = retry_q;
    assign pll_if.lost_lock_cnt = lost_q;

endmodule
